// File: rtl/spi_fill_arbiter_if.sv
// Bundle of cache-miss, SPI-controller and fill signals around spi_fill_arbiter.
// master = caches + SPI controller side, slave = the arbiter itself.
interface spi_fill_arbiter_if #(
  parameter int ADDR_W = 20
);
  logic              icache_miss;
  logic [ADDR_W-1:0] icache_addr;
  logic              dcache_miss;
  logic [ADDR_W-1:0] dcache_addr;
  logic              spi_start;
  logic [ADDR_W-1:0] spi_addr;
  logic              spi_data_ready;
  logic [31:0]       spi_data;
  logic [1:0]        mode;
  logic              icache_fill;
  logic              dcache_fill;
  logic [31:0]       fill_data;
  logic              timeout_err;

  modport master (
    output icache_miss, icache_addr, dcache_miss, dcache_addr,
    output spi_data_ready, spi_data,
    input  spi_start, spi_addr, mode, icache_fill, dcache_fill,
    input  fill_data, timeout_err
  );

  modport slave (
    input  icache_miss, icache_addr, dcache_miss, dcache_addr,
    input  spi_data_ready, spi_data,
    output spi_start, spi_addr, mode, icache_fill, dcache_fill,
    output fill_data, timeout_err
  );
endinterface

// File: rtl/spi_fill_arbiter.sv
// Arbitrates I/D-cache misses onto single-word SPI flash reads and returns each
// word as a one-cycle fill strobe; a watchdog re-issues reads that never return.
module spi_fill_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int TIMEOUT = 2048,
  parameter int TO_W    = 12
) (
  input logic               CLK,
  input logic               resetn,
  spi_fill_arbiter_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FILL, COOL} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [TO_W-1:0]   WD_LAST    = TO_W'(TIMEOUT - 1);

  state_t            state_q, state_n;
  logic [1:0]        owner_q, owner_n;
  logic              last_i_q, last_i_n;
  logic [TO_W-1:0]   wd_q, wd_n;
  logic [ADDR_W-1:0] addr_n;
  logic [31:0]       data_n;
  logic              err_n;
  logic              start_n;
  logic [1:0]        mode_n;
  logic              ifill_n;
  logic              dfill_n;

  // Every output is computed from the next state so it can be registered directly.
  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    last_i_n = last_i_q;
    wd_n     = wd_q;
    addr_n   = bus.spi_addr;
    data_n   = bus.fill_data;
    err_n    = bus.timeout_err;

    unique case (state_q)
      IDLE: begin
        // On a tie the cache that did not win last time gets the grant.
        if (bus.icache_miss && (!bus.dcache_miss || !last_i_q)) begin
          owner_n  = 2'b10;
          addr_n   = bus.icache_addr & ALIGN_MASK;
          last_i_n = 1'b1;
          state_n  = ISSUE;
        end else if (bus.dcache_miss) begin
          owner_n  = 2'b01;
          addr_n   = bus.dcache_addr & ALIGN_MASK;
          last_i_n = 1'b0;
          state_n  = ISSUE;
        end
      end
      ISSUE: begin
        wd_n    = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (bus.spi_data_ready) begin
          data_n  = bus.spi_data;
          state_n = FILL;
        end else if (wd_q == WD_LAST) begin
          err_n   = 1'b1;
          state_n = ISSUE;
        end else begin
          wd_n = wd_q + TO_W'(1);
        end
      end
      FILL:    state_n = COOL;
      COOL:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    start_n = (state_n == ISSUE);
    mode_n  = (state_n == ISSUE || state_n == WAIT || state_n == FILL) ? owner_n : 2'b00;
    ifill_n = (state_n == FILL) && owner_n[1];
    dfill_n = (state_n == FILL) && owner_n[0];
  end

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q         <= IDLE;
      owner_q         <= 2'b00;
      last_i_q        <= 1'b1;
      wd_q            <= '0;
      bus.spi_start   <= 1'b0;
      bus.spi_addr    <= '0;
      bus.mode        <= 2'b00;
      bus.icache_fill <= 1'b0;
      bus.dcache_fill <= 1'b0;
      bus.fill_data   <= '0;
      bus.timeout_err <= 1'b0;
    end else begin
      state_q         <= state_n;
      owner_q         <= owner_n;
      last_i_q        <= last_i_n;
      wd_q            <= wd_n;
      bus.spi_start   <= start_n;
      bus.spi_addr    <= addr_n;
      bus.mode        <= mode_n;
      bus.icache_fill <= ifill_n;
      bus.dcache_fill <= dfill_n;
      bus.fill_data   <= data_n;
      bus.timeout_err <= err_n;
    end
  end
endmodule
